// File: rtl/axis_gen_pkg.sv
// axis_gen_pkg: types and constants for the AXI-Stream burst generator.
//   state_t       - generator FSM states
//   LFSR_POLY     - Galois feedback mask for x^32+x^22+x^2+x+1
//   DEFAULT_SEED  - reset value of LFSR lane 0
//   lfsr_step()   - one step of a 32-bit lane
package axis_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  // Right-shifting Galois form: taps 32,22,2,1 map to bits 31,21,1,0.
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/axis_gen_lfsr.sv
// axis_gen_lfsr: one 32-bit Galois LFSR lane of the payload generator.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, loads seed
//   seed  - reset value of this lane
//   step  - advance one position this cycle
//   q     - current lane value
module axis_gen_lfsr
  import axis_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/axis_burst_gen.sv
// axis_burst_gen: emits one AXI-Stream burst of burst_len+2 beats per start,
// after an optional idle gap. Payload is DATA_W/32 LFSR lanes; the last beat
// carries an MSB-aligned keep of a fixed or LFSR-derived byte count.
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - launch request, honoured only in IDLE
//   burst_len       - middle beat count (total beats = burst_len+2)
//   gap             - idle cycles between start and first beat
//   tail_bytes      - last-beat byte count (0 or >KEEP_W means full)
//   rand_keep       - take last-beat byte count from the LFSR instead
//   m_tready        - downstream ready
//   m_tvalid/tlast/tkeep/tdata - registered AXI-Stream master outputs
//   busy            - high outside IDLE
//   done            - one-cycle pulse after the last-beat handshake
//   dbg_state       - current FSM state
//
// Handshake: a beat transfers on a rising edge where m_tvalid & m_tready.
// Once m_tvalid is raised it stays high, with tdata/tkeep/tlast frozen,
// until that beat transfers; the beat counter and LFSRs move only then.
module axis_burst_gen
  import axis_gen_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter int          LEN_W  = 8,
  parameter int          GAP_W  = 10,
  parameter logic [31:0] SEED   = DEFAULT_SEED,
  localparam int         KEEP_W = DATA_W / 8,
  localparam int         TB_W   = $clog2(KEEP_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [GAP_W-1:0]  gap,
  input  logic [TB_W-1:0]   tail_bytes,
  input  logic              rand_keep,
  input  logic              m_tready,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic [DATA_W-1:0] m_tdata,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  localparam int              N_LANES = DATA_W / 32;
  localparam int              CNT_W   = LEN_W + 1;
  localparam logic [TB_W-1:0] KEEP_N  = TB_W'(KEEP_W);
  localparam logic [TB_W-1:0] ONE_N   = TB_W'(1);

  if (DATA_W < 32 || (DATA_W % 32) != 0) begin : g_bad_width
    $error("axis_burst_gen: DATA_W must be a positive multiple of 32");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;       // index of the beat currently presented
  logic [GAP_W-1:0]   gap_cnt;
  logic [LEN_W-1:0]   len_q;
  logic [TB_W-1:0]    tb_q;
  logic               rk_q;

  logic [DATA_W-1:0]  lfsr_q;
  logic [DATA_W-1:0]  lfsr_nxt;
  logic               hs;

  // Description of the beat that will be loaded into the output registers.
  logic [CNT_W-1:0]   nb_idx;
  logic [DATA_W-1:0]  nb_data;
  logic [LEN_W-1:0]   nb_len;
  logic [TB_W-1:0]    nb_tb;
  logic               nb_rk;
  logic               nb_last;
  logic [TB_W-1:0]    nb_r;
  logic [TB_W-1:0]    nb_n;
  logic [KEEP_W-1:0]  nb_keep;

  assign hs        = m_tvalid & m_tready;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    axis_gen_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (SEED ^ 32'(i)),
      .step  (hs),
      .q     (lfsr_q[i*32 +: 32])
    );
    // Lookahead so the beat after a handshake shows the stepped value.
    assign lfsr_nxt[i*32 +: 32] = lfsr_step(lfsr_q[i*32 +: 32]);
  end

  always_comb begin
    nb_len  = len_q;
    nb_tb   = tb_q;
    nb_rk   = rk_q;
    nb_data = lfsr_q;
    nb_idx  = '0;
    if (state == S_IDLE) begin
      // First beat straight out of IDLE: configuration not yet latched.
      nb_len = burst_len;
      nb_tb  = tail_bytes;
      nb_rk  = rand_keep;
    end else if (state == S_SEND) begin
      nb_data = lfsr_nxt;
      nb_idx  = cnt + CNT_W'(1);
    end
    nb_last = (nb_idx == ({1'b0, nb_len} + CNT_W'(1)));
    // Random byte count uses the low bits of lane 0 of the beat itself.
    nb_r    = {1'b0, nb_data[TB_W-2:0]};
    if (nb_rk) begin
      nb_n = (nb_r % KEEP_N) + ONE_N;
    end else if (nb_tb == '0 || nb_tb > KEEP_N) begin
      nb_n = KEEP_N;
    end else begin
      nb_n = nb_tb;
    end
    nb_keep = nb_last ? ~({KEEP_W{1'b1}} >> nb_n) : {KEEP_W{1'b1}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gap_cnt  <= '0;
      len_q    <= '0;
      tb_q     <= '0;
      rk_q     <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tkeep  <= '0;
      m_tdata  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= burst_len;
            tb_q  <= tail_bytes;
            rk_q  <= rand_keep;
            cnt   <= '0;
            if (gap != '0) begin
              state   <= S_GAP;
              gap_cnt <= gap - GAP_W'(1);
            end else begin
              state    <= S_SEND;
              m_tvalid <= 1'b1;
              m_tdata  <= nb_data;
              m_tkeep  <= nb_keep;
              m_tlast  <= nb_last;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state    <= S_SEND;
            cnt      <= '0;
            m_tvalid <= 1'b1;
            m_tdata  <= nb_data;
            m_tkeep  <= nb_keep;
            m_tlast  <= nb_last;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_SEND: begin
          if (hs) begin
            if (m_tlast) begin
              state    <= S_IDLE;
              cnt      <= '0;
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              m_tkeep  <= '0;
              m_tdata  <= '0;
              done     <= 1'b1;
            end else begin
              cnt     <= nb_idx;
              m_tdata <= nb_data;
              m_tkeep <= nb_keep;
              m_tlast <= nb_last;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
